// File: rtl/sopc_rst_ctrl_if.sv
// sopc_rst_ctrl_if: run-control bundle between the SoC bench (master) and sopc_rst_ctrl (slave); halt/restart requests in, core reset and run status out
interface sopc_rst_ctrl_if #(parameter int CNT_W = 16);
  logic halt_req_i;
  logic restart_i;
  logic cpu_rst_o;
  logic running_o;
  logic halted_o;
  logic timeout_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  modport master (
    output halt_req_i, restart_i,
    input  cpu_rst_o, running_o, halted_o, timeout_o, cycle_cnt_o
  );
  modport slave (
    input  halt_req_i, restart_i,
    output cpu_rst_o, running_o, halted_o, timeout_o, cycle_cnt_o
  );
endinterface

// File: rtl/sopc_rst_ctrl.sv
// sopc_rst_ctrl: reset stretcher and run sequencer for openmips_min_sopc (clk, sync active-high rst, bus: halt_req_i/restart_i in; cpu_rst_o/running_o/halted_o/timeout_o/cycle_cnt_o out)
module sopc_rst_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int RUN_BUDGET  = 50,
  parameter int CNT_W       = 16
) (
  input logic            clk,
  input logic            rst,
  sopc_rst_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RESET, HOLD, RUN, HALT} state_t;
  localparam logic [7:0]       HOLD_LAST   = 8'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(RUN_BUDGET - 1);
  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic             expire;
  assign expire = (RUN_BUDGET != 0) && (cnt_q == BUDGET_LAST);
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      RESET: begin
        state_d = HOLD;
        hold_d  = '0;
      end
      HOLD: begin
        hold_d  = hold_q + 8'd1;
        state_d = (hold_q == HOLD_LAST) ? RUN : HOLD;
      end
      RUN: begin
        cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
        state_d = (bus.halt_req_i || expire) ? HALT : RUN;
        // an explicit halt request masks a coincident budget expiry
        to_d    = !bus.halt_req_i && expire;
      end
      HALT: begin
        if (bus.restart_i) begin
          state_d = HOLD;
          hold_d  = '0;
          cnt_d   = '0;
          to_d    = 1'b0;
        end
      end
      default: state_d = RESET;
    endcase
    // status flops are loaded from the next state so outputs stay purely registered
    cpu_rst_d = state_d != RUN;
    running_d = state_d == RUN;
    halted_d  = state_d == HALT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET;
      hold_q    <= '0;
      cnt_q     <= '0;
      to_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      cpu_rst_q <= cpu_rst_d;
      running_q <= running_d;
      halted_q  <= halted_d;
    end
  end
  assign bus.cpu_rst_o   = cpu_rst_q;
  assign bus.running_o   = running_q;
  assign bus.halted_o    = halted_q;
  assign bus.timeout_o   = to_q;
  assign bus.cycle_cnt_o = cnt_q;
endmodule
